dm_store_buffer: RTL and testbench

- Posted-write buffer between the CPU store path and the data memory.
- Accepts word stores, holds up to DEPTH of them in FIFO order, and drains one per cycle into the DM write port whenever no load needs the port.
- Owns the DM address mux.
- Loads read through this block: a word still in the buffer is forwarded, otherwise DM data is passed back.

---
 rtl/dm_store_buffer_pkg.sv | 19 +
 rtl/dm_sb_match.sv | 32 +++
 rtl/dm_store_buffer.sv | 123 ++++++++++++
 tb/tb_dm_store_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dm_store_buffer_pkg.sv
// Shared entry layout for the data-memory store buffer.
// Entry word is {pc, waddr, data}, with data in the low bits.
package dm_store_buffer_pkg;

  localparam int WADDR_W    = 30;
  localparam int SB_ENTRY_W = 94;
  localparam int DATA_LSB   = 0;
  localparam int WADDR_LSB  = 32;
  localparam int PC_LSB     = 62;

  function automatic logic [SB_ENTRY_W-1:0] pack_entry(
    input logic [31:0]        pc,
    input logic [WADDR_W-1:0] waddr,
    input logic [31:0]        data
  );
    return {pc, waddr, data};
  endfunction

endpackage

// File: rtl/dm_sb_match.sv
// Youngest-match search over the store buffer for load forwarding.
// Valid entries are contiguous from head, so scanning from oldest to youngest and keeping the last hit gives the youngest match.
module dm_sb_match
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][WADDR_W-1:0] waddr,
  input  logic [PTR_W-1:0]              head,
  input  logic [WADDR_W-1:0]            ld_waddr,
  output logic                          hit,
  output logic [PTR_W-1:0]              idx
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    hit = 1'b0;
    idx = head;
    pos = head;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head + PTR_W'(i);
      if (valid[pos] && (waddr[pos] == ld_waddr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer between the CPU store path and data memory, with load forwarding.
// Optional store coalescing into the youngest entry: define DM_STORE_BUF_COALESCE_EN.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_pc,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_data,
  output logic             ld_hit,
  input  logic [31:0]      dm_rdata,
  output logic             dm_we,
  output logic [31:0]      dm_pc,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SB_ENTRY_W-1:0]         mem [DEPTH];
  logic [DEPTH-1:0]              valid;
  logic [PTR_W-1:0]              head;
  logic [PTR_W-1:0]              tail;
  logic [PTR_W-1:0]              youngest;
  logic [PTR_W-1:0]              hit_idx;
  logic [DEPTH-1:0][WADDR_W-1:0] waddr_arr;
  logic [SB_ENTRY_W-1:0]         head_e;
  logic                          full;
  logic                          push;
  logic                          pop;
  logic                          coal;
  logic                          hit;
  logic                          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign youngest = tail - PTR_W'(1);
  assign head_e   = mem[head];

  // Loads own the DM port; the head drains only on cycles without a load.
  assign dm_we    = !empty && !ld_valid && !reset;
  assign pop      = dm_we;
  assign dm_addr  = ld_valid ? ld_addr : {head_e[WADDR_LSB +: WADDR_W], 2'b00};
  assign dm_wdata = head_e[DATA_LSB +: 32];
  assign dm_pc    = head_e[PC_LSB +: 32];

`ifdef DM_STORE_BUF_COALESCE_EN
  // Merging is unsafe when the youngest entry is also the one leaving this cycle.
  assign coal = st_valid && !empty
              && (mem[youngest][WADDR_LSB +: WADDR_W] == st_addr[31:2])
              && !(pop && (count == CNT_W'(1)));
  assign st_ready = !full || coal;
`else
  assign coal     = 1'b0;
  assign st_ready = !full;
`endif

  assign push = st_valid && st_ready && !coal;

  always_comb begin
    waddr_arr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      waddr_arr[i] = mem[i][WADDR_LSB +: WADDR_W];
    end
  end

  dm_sb_match #(.DEPTH(DEPTH)) u_match (
    .valid    (valid),
    .waddr    (waddr_arr),
    .head     (head),
    .ld_waddr (ld_addr[31:2]),
    .hit      (hit),
    .idx      (hit_idx)
  );

  assign ld_hit  = hit;
  assign ld_data = hit ? mem[hit_idx][DATA_LSB +: 32] : dm_rdata;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= pack_entry(st_pc, st_addr[31:2], st_data);
    end else if (coal) begin
      mem[youngest] <= pack_entry(st_pc, st_addr[31:2], st_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: a queue model of pending DM writes checked every cycle.
// The model follows DM_STORE_BUF_COALESCE_EN when it is defined for the build.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_pc;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_ready;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_data;
  logic             ld_hit;
  logic [31:0]      dm_rdata;
  logic             dm_we;
  logic [31:0]      dm_pc;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [CNT_W-1:0] count;
  logic             empty;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_pc    (st_pc),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_hit   (ld_hit),
    .dm_rdata (dm_rdata),
    .dm_we    (dm_we),
    .dm_pc    (dm_pc),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .count    (count),
    .empty    (empty)
  );

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [31:0] pc;
  } store_t;

  // Pending stores in program order; the front is the next DM write expected.
  store_t exp_q[$];
  int     checks = 0;
  int     fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic lv, input logic [31:0] la);
    @(posedge clk);
    #1;
    reset    = r;
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_pc    = $urandom;
    ld_valid = lv;
    ld_addr  = la;
    dm_rdata = $urandom;
  endtask

  // Monitor: compare DUT outputs with the model, then advance the model to the next edge.
  always @(negedge clk) begin : monitor
    int     n;
    logic   exp_we;
    logic   exp_ready;
    logic   merge;
    logic   found;
    store_t s;
    store_t hit_s;

    n         = exp_q.size();
    exp_we    = (n != 0) && !ld_valid && !reset;
    merge     = 1'b0;
`ifdef DM_STORE_BUF_COALESCE_EN
    merge = st_valid && (n > 0) && (exp_q[n-1].waddr == st_addr[31:2]) && !(exp_we && n == 1);
`endif
    exp_ready = (n != DEPTH) || merge;

    checkOutput("count", 32'(count), 32'(n));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("st_ready", 32'(st_ready), 32'(exp_ready));
    checkOutput("dm_we", 32'(dm_we), 32'(exp_we));
    if (exp_we && n > 0) begin
      checkOutput("drain_addr", dm_addr, {exp_q[0].waddr, 2'b00});
      checkOutput("drain_data", dm_wdata, exp_q[0].data);
      checkOutput("drain_pc", dm_pc, exp_q[0].pc);
    end
    if (ld_valid) begin
      found = 1'b0;
      hit_s = '{waddr: '0, data: '0, pc: '0};
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && exp_q[i].waddr == ld_addr[31:2]) begin
          found = 1'b1;
          hit_s = exp_q[i];
        end
      end
      checkOutput("ld_dm_addr", dm_addr, ld_addr);
      checkOutput("ld_hit", 32'(ld_hit), 32'(found));
      checkOutput("ld_data", ld_data, found ? hit_s.data : dm_rdata);
    end

    if (reset) begin
      exp_q.delete();
    end else begin
      if (exp_we) void'(exp_q.pop_front());
      s = '{waddr: st_addr[31:2], data: st_data, pc: st_pc};
      if (merge) exp_q[exp_q.size()-1] = s;
      else if (st_valid && exp_ready) exp_q.push_back(s);
    end
  end

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_pc    = '0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    dm_rdata = '0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single store drains on the following cycle.
    applyStimulus(0, 1, 32'h10, 32'hAAAA5555, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

    // Fill while loads block the port, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'(i * 4), 32'h100 + 32'(i), 1, 32'h300);
    applyStimulus(0, 0, 0, 0, 1, 32'h300);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

    // Youngest-match forwarding and a miss.
    applyStimulus(0, 1, 32'h20, 32'd1, 1, 32'h300);
    applyStimulus(0, 1, 32'h20, 32'd2, 1, 32'h300);
    applyStimulus(0, 0, 0, 0, 1, 32'h20);
    applyStimulus(0, 0, 0, 0, 1, 32'h24);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Full with a simultaneous drain: store refused, accepted the next cycle.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h80 + 32'(i * 4), 32'h500 + 32'(i), 1, 32'h300);
    applyStimulus(0, 1, 32'h50, 32'h5050, 0, 0);
    applyStimulus(0, 1, 32'h50, 32'h5050, 1, 32'h300);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset with entries buffered discards them.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h60 + 32'(i * 4), 32'h600 + 32'(i), 1, 32'h300);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h64);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Back-to-back stores to one word (merged when coalescing is built in).
    applyStimulus(0, 1, 32'h40, 32'h4001, 1, 32'h300);
    applyStimulus(0, 1, 32'h40, 32'h4002, 1, 32'h300);
    applyStimulus(0, 0, 0, 0, 1, 32'h40);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic over a small address window to provoke hits and wraps.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 60),
                    32'h200 + (32'($urandom_range(0, 7)) << 2),
                    $urandom,
                    ($urandom_range(0, 99) < 35),
                    32'h200 + (32'($urandom_range(0, 7)) << 2));
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
